// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock-qualification sequencer running on the PLL reference clock.
// Optional retry limit with a terminal FAIL state: define PLL_SUP_RETRY_LIMIT_EN.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       relock_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic [7:0] lock_lost_cnt,
  output logic [1:0] sup_state,
  output logic       fail
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that saw lk=1 is the first stable cycle, so STABILISE needs one fewer.
  localparam logic [STB_W-1:0] STB_LAST = STB_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int RTY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
`endif

  // Low two bits are the externally visible sup_state; RUN and FAIL share 2'b11.
  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILISE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [7:0]       lost_q, lost_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic [1:0]       sup_state_q, sup_state_d;
  logic             lk;
  logic             restart;
  logic             stay;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             fail_q, fail_d;
`endif

  assign lk = sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET_PLL;
      sync_q        <= '0;
      rst_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      stb_cnt_q     <= '0;
      lost_q        <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      sup_state_q   <= 2'b00;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      retry_q       <= '0;
      fail_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      rst_cnt_q     <= rst_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stb_cnt_q     <= stb_cnt_d;
      lost_q        <= lost_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      sup_state_q   <= sup_state_d;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      retry_q       <= retry_d;
      fail_q        <= fail_d;
`endif
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], pll_locked};
    state_d = state_q;
    lost_d  = lost_q;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    retry_d = retry_q;
`endif
    restart = relock_req && (state_q != S_FAIL);
    // A lock loss in RUN is counted even when relock_req wins the transition.
    if ((state_q == S_RUN) && !lk && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;

    if (restart) begin
      state_d = S_RESET_PLL;
    end else begin
      case (state_q)
        S_RESET_PLL: if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lk) begin
            state_d = (STABLE_CYCLES > 1) ? S_STABILISE : S_RUN;
          end else if (tmo_cnt_q == TMO_LAST) begin
`ifdef PLL_SUP_RETRY_LIMIT_EN
            if (retry_q == RTY_LAST) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 1'b1;
            end
`else
            state_d = S_RESET_PLL;
`endif
          end
        end
        S_STABILISE: begin
          if (!lk) state_d = S_WAIT_LOCK;
          else if (stb_cnt_q == STB_LAST) state_d = S_RUN;
        end
        S_RUN: if (!lk) state_d = S_RESET_PLL;
`ifdef PLL_SUP_RETRY_LIMIT_EN
        S_FAIL: state_d = S_FAIL;
`endif
        default: state_d = S_RESET_PLL;
      endcase
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    if ((state_d == S_RUN) && (state_q != S_RUN)) retry_d = '0;
`endif

    // Every counter restarts from zero whenever its state is (re)entered.
    stay      = (state_d == state_q) && !restart;
    rst_cnt_d = (stay && (state_q == S_RESET_PLL)) ? rst_cnt_q + 1'b1 : '0;
    tmo_cnt_d = (stay && (state_q == S_WAIT_LOCK)) ? tmo_cnt_q + 1'b1 : '0;
    stb_cnt_d = (stay && (state_q == S_STABILISE)) ? stb_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    pll_rst_d     = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_reset_n_d = (state_d == S_RUN);
    sup_state_d   = state_d[1:0];
`ifdef PLL_SUP_RETRY_LIMIT_EN
    fail_d        = (state_d == S_FAIL);
`endif
  end

  assign pll_rst       = pll_rst_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign lock_lost_cnt = lost_q;
  assign sup_state     = sup_state_q;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  assign fail          = fail_q;
`else
  assign fail          = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed sequences plus a random phase, all cycles
// scored against a phase/elapsed-time reference model through an expected queue.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 64;
  localparam int STABLE_CYCLES = 16;
  localparam int MAX_RETRIES   = 3;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT = 1'b1;
`else
  localparam bit RETRY_LIMIT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       refclk      = 1'b0;
  logic       rst_n       = 1'b1;
  logic       relock_req  = 1'b0;
  logic       pll_locked  = 1'b0;
  logic       pll_rst;
  logic       sys_reset_n;
  logic [7:0] lock_lost_cnt;
  logic [1:0] sup_state;
  logic       fail;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .relock_req   (relock_req),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_reset_n  (sys_reset_n),
    .lock_lost_cnt(lock_lost_cnt),
    .sup_state    (sup_state),
    .fail         (fail)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] pack(input logic prst, input logic srn, input logic [7:0] lost,
                                       input logic [1:0] st, input logic f);
    return {prst, srn, lost, st, f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mphase_e;
  mphase_e m_phase = M_RST;
  int      m_cyc   = 0;
  int      m_start = 0;
  int      m_tries = 0;
  int      m_lost  = 0;
  logic    m_s1    = 1'b0;
  logic    m_s2    = 1'b0;

  task automatic m_enter(input mphase_e p);
    m_phase = p;
    m_start = m_cyc;
  endtask

  function automatic logic [1:0] m_code(input mphase_e p);
    case (p)
      M_RST:   return 2'd0;
      M_WAIT:  return 2'd1;
      M_STAB:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always @(posedge refclk or negedge rst_n) begin : ref_model
    logic lk;
    if (!rst_n) begin
      m_phase = M_RST;
      m_cyc   = 0;
      m_start = 0;
      m_tries = 0;
      m_lost  = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      exp_q.delete();
    end else begin
      // lk is the pll_locked value seen two edges earlier.
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      m_cyc++;
      if (m_phase == M_RUN && !lk && m_lost < 255) m_lost++;
      if (relock_req && m_phase != M_FAIL) begin
        m_enter(M_RST);
      end else begin
        case (m_phase)
          M_RST: if (m_cyc - m_start == RST_CYCLES) m_enter(M_WAIT);
          M_WAIT: begin
            if (lk) m_enter(M_STAB);
            else if (m_cyc - m_start == LOCK_TIMEOUT) begin
              m_tries++;
              if (RETRY_LIMIT && m_tries >= MAX_RETRIES) m_enter(M_FAIL);
              else m_enter(M_RST);
            end
          end
          M_STAB: begin
            // lk high on STABLE_CYCLES consecutive edges, counting the one that left WAIT.
            if (!lk) m_enter(M_WAIT);
            else if (m_cyc - m_start == STABLE_CYCLES - 1) begin
              m_enter(M_RUN);
              m_tries = 0;
            end
          end
          M_RUN: if (!lk) m_enter(M_RST);
          default: ;
        endcase
      end
      exp_q.push_back(pack(m_phase == M_RST || m_phase == M_FAIL, m_phase == M_RUN,
                           8'(m_lost), m_code(m_phase), m_phase == M_FAIL));
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge refclk) begin : monitor
    logic [12:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = pack(pll_rst, sys_reset_n, lock_lost_cnt, sup_state, fail);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL scoreboard t=%0t: got rst=%b srn=%b lost=%0d st=%0d fail=%b, expected rst=%b srn=%b lost=%0d st=%0d fail=%b",
                    $time, a[12], a[11], a[10:3], a[2:1], a[0], e[12], e[11], e[10:3], e[2:1], e[0]);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic sel(input int which);
    case (which)
      0:       return sys_reset_n;
      1:       return pll_rst;
      2:       return sup_state == 2'd2;
      default: return sup_state == 2'd1;
    endcase
  endfunction

  // Counts falling edges until the selected condition equals val; expiry is a failed check.
  task automatic wait_for(input int which, input logic val, input int budget, input string name,
                          output int cycles);
    cycles = 0;
    while (sel(which) !== val && cycles < budget) begin
      @(negedge refclk);
      cycles++;
    end
    if (sel(which) !== val) begin
      n_checks++;
      $display("FAIL %s: condition not reached in %0d cycles, required within budget", name, budget);
    end
  endtask

  task automatic apply_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic bring_up();
    int c;
    relock_req = 1'b0;
    pll_locked = 1'b1;
    wait_for(0, 1'b1, 300, "bring_up", c);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int  c, c2, exp_lost;
    bit  seen_wait;
    #1 rst_n = 1'b0;
    #1;
    check("reset_pll_rst", pll_rst, 1);
    check("reset_sys_reset_n", sys_reset_n, 0);
    check("reset_lost", lock_lost_cnt, 0);
    check("reset_state", sup_state, 0);
    check("reset_fail", fail, 0);
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;

    // 1: power-up sequence
    wait_for(1, 1'b0, 50, "t1_pll_rst_fall", c);
    check("t1_pll_rst_width", c, RST_CYCLES);
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    wait_for(0, 1'b1, 200, "t1_release", c);
    check("t1_release_delay", c, 2 + STABLE_CYCLES);
    check("t1_state_run", sup_state, 3);
    check("t1_pll_rst_low", pll_rst, 0);

    // 2: one-cycle lock drop in RUN
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    wait_for(0, 1'b0, 10, "t2_drop", c);
    check("t2_drop_delay", c + 1, 3);
    exp_lost = 1;
    check("t2_lost", lock_lost_cnt, exp_lost);
    wait_for(1, 1'b0, 20, "t2_pulse_end", c);
    check("t2_pll_rst_width", c, RST_CYCLES);
    wait_for(0, 1'b1, 100, "t2_relock", c);

    // 3: lock never returns
    pll_locked = 1'b0;
    wait_for(1, 1'b1, 10, "t3_first_rst", c);
    exp_lost++;
    check("t3_lost", lock_lost_cnt, exp_lost);
    for (int k = 0; k < 3; k++) begin
      wait_for(1, 1'b0, 100, "t3_fall", c);
      wait_for(1, 1'b1, 100, "t3_rise", c2);
      check("t3_period", c + c2, RST_CYCLES + LOCK_TIMEOUT);
    end
`ifdef PLL_SUP_RETRY_LIMIT_EN
    check("t3_fail", fail, 1);
    repeat (80) @(negedge refclk);
    check("t3_fail_hold", fail, 1);
    check("t3_fail_pll_rst", pll_rst, 1);
    check("t3_fail_state", sup_state, 3);
    check("t3_fail_sys_reset_n", sys_reset_n, 0);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    repeat (10) @(negedge refclk);
    check("t3_fail_ignores_relock", fail, 1);
    check("t3_fail_relock_pll_rst", pll_rst, 1);
    apply_reset();
    exp_lost = 0;
`else
    wait_for(1, 1'b0, 100, "t3_fall4", c);
    wait_for(1, 1'b1, 100, "t3_rise4", c2);
    check("t3_period4", c + c2, RST_CYCLES + LOCK_TIMEOUT);
    check("t3_no_fail", fail, 0);
`endif
    bring_up();

    // 4: lock glitch during STABILISE
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    wait_for(2, 1'b1, 20, "t4_enter_stab", c);
    repeat (10) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    c = 0;
    seen_wait = 1'b0;
    while (!sys_reset_n && c < 100) begin
      @(negedge refclk);
      c++;
      if (sup_state == 2'd1) seen_wait = 1'b1;
    end
    check("t4_saw_wait", seen_wait, 1);
    check("t4_release_delay", c, 2 + STABLE_CYCLES);
    check("t4_lost_unchanged", lock_lost_cnt, exp_lost);

    // 5: relock_req coinciding with a lock loss in RUN
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    exp_lost++;
    check("t5_sys_reset_n", sys_reset_n, 0);
    check("t5_lost", lock_lost_cnt, exp_lost);
    wait_for(1, 1'b0, 20, "t5_pulse_end", c);
    check("t5_pll_rst_width", c, RST_CYCLES);
    wait_for(0, 1'b1, 100, "t5_relock", c);

    // random phase: bursts of lock toggling and sporadic relock requests
    for (int i = 0; i < 2500; i++) begin
      @(negedge refclk);
      if ($urandom_range(0, 10 + 20 * (i / 500)) == 0) pll_locked = ~pll_locked;
      relock_req = ($urandom_range(0, 99) == 0);
    end
    @(negedge refclk);
    relock_req = 1'b0;
    if (fail) apply_reset();
    bring_up();

    // 6: saturation of the lock-loss counter, then asynchronous reset mid-WAIT_LOCK
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      wait_for(0, 1'b0, 10, "t6_drop", c);
      wait_for(0, 1'b1, 60, "t6_relock", c);
    end
    check("t6_lost_saturated", lock_lost_cnt, 255);
    pll_locked = 1'b0;
    wait_for(3, 1'b1, 20, "t6_wait_lock", c);
    repeat (5) @(negedge refclk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_pll_rst", pll_rst, 1);
    check("t6_async_sys_reset_n", sys_reset_n, 0);
    check("t6_async_lost", lock_lost_cnt, 0);
    check("t6_async_state", sup_state, 0);
    check("t6_async_fail", fail, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (5) @(negedge refclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
